// File: rtl/proc_pkg.sv
// Shared processor-wide constants and helpers.
// Used by storage blocks driven from the temp/ALU path.
package proc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam logic WR_ACTIVE = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/temp_buf_mem.sv
// Register array for the temp read buffer.
// Falling-edge write port, asynchronous read port.
module temp_buf_mem
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/temp_read_buffer.sv
// FWFT queue holding temp-path results until read.
// Active-low write strobe in, valid/ready drain out.
module temp_read_buffer
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] temp_in,
  input  logic              reg_wr,
  output logic              wr_full,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              we;

  assign push_req = (reg_wr == WR_ACTIVE);
  assign rd_valid = (count != '0);
  assign wr_full  = (count == FULL_CNT);
  assign pop      = rd_valid & rd_ready;
  // A pop on the same edge frees the slot a full push needs.
  assign push     = push_req & (~wr_full | pop);
  assign we       = push & rst_n;
  assign rd_data  = rd_valid ? head : '0;

  temp_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (temp_in),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  a_wr_known: assert property (
    @(negedge clk) disable iff (!rst_n) !$isunknown(reg_wr)
  );

endmodule

// File: tb/tb_temp_read_buffer.sv
// Bench for temp_read_buffer: directed plan plus random
// traffic against a queue-based reference model.
module tb_temp_read_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] temp_in = '0;
  logic        reg_wr = 1'b1;
  logic        rd_ready = 1'b0;
  logic        wr_full;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  logic [15:0] q[$];
  bit          m_ovf = 1'b0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  temp_read_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .temp_in  (temp_in),
    .reg_wr   (reg_wr),
    .wr_full  (wr_full),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, drive inputs, then advance the
  // model across the falling edge.
  task automatic cyc(input logic r, input logic w,
                     input logic [15:0] d, input logic rdy);
    bit pop;
    bit full;
    @(posedge clk);
    #1;
    if (armed) begin
      check("count", 32'(count), 32'(q.size()));
      check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
      check("wr_full", 32'(wr_full), 32'(q.size() == 4));
      check("rd_data", 32'(rd_data),
            (q.size() != 0) ? 32'(q[0]) : 32'h0);
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
    rst_n = r;
    reg_wr = w;
    temp_in = d;
    rd_ready = rdy;
    @(negedge clk);
    #1;
    if (!r) begin
      q.delete();
      m_ovf = 1'b0;
      armed = 1'b1;
    end else begin
      full = (q.size() == 4);
      pop = (q.size() != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (!w) begin
        if (!full || pop) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic push(input logic [15:0] d, input logic rdy);
    cyc(1'b1, 1'b0, d, rdy);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b1, 1'b1, 16'h0, rdy);
  endtask

  task automatic rst1();
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
  endtask

  initial begin
    rst1();
    rst1();
    idle(1'b0);
    idle(1'b1);

    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    push(16'h3333, 1'b0);
    push(16'h4444, 1'b0);
    repeat (5) idle(1'b1);

    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    push(16'h3333, 1'b0);
    push(16'h4444, 1'b0);
    push(16'hDEAD, 1'b0);
    repeat (5) idle(1'b1);

    rst1();
    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    push(16'h3333, 1'b0);
    push(16'h4444, 1'b0);
    push(16'h5555, 1'b1);
    repeat (5) idle(1'b1);

    for (int i = 1; i <= 10; i++) push(16'(i), 1'b1);
    repeat (2) idle(1'b1);

    push(16'hA001, 1'b0);
    push(16'hA002, 1'b0);
    push(16'hA003, 1'b0);
    cyc(1'b0, 1'b0, 16'hBEEF, 1'b0);
    repeat (2) idle(1'b0);
    repeat (3) idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 49) != 0),
          logic'($urandom_range(0, 9) >= 6),
          16'($urandom),
          logic'($urandom_range(0, 1)));
    end
    repeat (6) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_read_buffer.md
Name: temp_read_buffer

Overview:
- Small first-word-fall-through (FWFT) queue. It accepts 16-bit datapath results through a write port: `temp_in` plus an active-low write strobe `reg_wr`.
- The consumer side drains it through a `rd_valid`/`rd_ready` handshake.
- Sits between the ALU/temp path and downstream consumers (writeback, output port). Results are held in order until read, instead of being overwritten each cycle.

Parameters:
- DATA_W, 16, word width.
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- ADDR_W, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the falling edge of clk.
- rst_n  input  1  reset, synchronous, active-low.
- temp_in  input  DATA_W  write data.
- reg_wr  input  1  write strobe, active-low; 0 requests a push.
- wr_full  output  1  1 when count == DEPTH.
- rd_data  output  DATA_W  head entry; 0 when empty.
- rd_valid  output  1  1 when count != 0.
- rd_ready  input  1  consumer accepts head this edge when rd_valid = 1.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky error flag: a push was dropped.

Behaviour:
- Reset (rst_n = 0 sampled at a falling edge):
  - wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0.
  - Outputs: rd_valid = 0, wr_full = 0, rd_data = 0.
  - Memory contents are not cleared; they are unobservable while empty.
  - Reset mid-operation discards all entries; no push or pop completes on that edge.
- push_req = (reg_wr == 0). pop = rd_valid & rd_ready.
- Push accepted when push_req & (!wr_full | pop):
  - mem[wr_ptr] <= temp_in; wr_ptr increments mod DEPTH.
- Pop:
  - rd_ptr increments mod DEPTH. The popped word is the rd_data value present before the edge.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full with simultaneous pop: push accepted; count stays DEPTH; wr_full stays 1.
- Full with no pop: push dropped; memory and pointers unchanged; overflow <= 1. overflow holds until reset.
- Empty with rd_ready = 1: no pop, no pointer change. rd_ready is ignored when empty.
- Empty with push: the entry appears at rd_data with rd_valid = 1 after the same falling edge. Latency is 1 edge; there is no empty-bypass, so the word is never visible combinationally in the same cycle.
- rd_data, rd_valid, wr_full and count are combinational from registered state: mem[rd_ptr] gated by !empty, and the count compares. No input-to-output combinational path exists.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally. Full/empty come from count, not pointer equality.
- X on reg_wr is treated as no push (defensive). Simulation-only assertion: reg_wr is never X out of reset.

Decomposition:
- Shared package `proc_pkg` holds:
  - DATA_W_DEF = 16.
  - Active-low strobe constant WR_ACTIVE = 1'b0, shared with all storage blocks using `reg_wr`.
  - A clog2 helper function.
- One natural sub-module: `temp_buf_mem`, a DEPTH x DATA_W register array with one write port (falling-edge write) and one asynchronous read port.
- Pointer, count and flag logic stay in `temp_read_buffer`.

Test Plan:
- Reset then idle: rst_n = 0 for 2 edges, then 1 → count = 0, rd_valid = 0, wr_full = 0, rd_data = 16'h0000, overflow = 0.
- Fill and drain in order:
  - Push 16'h1111, 16'h2222, 16'h3333, 16'h4444 with rd_ready = 0 → wr_full = 1, count = 4.
  - Then rd_ready = 1 → rd_data sequence 1111, 2222, 3333, 4444; rd_valid drops after the 4th pop.
- Overflow: on a full buffer, push 16'hDEAD with rd_ready = 0 → dropped, overflow = 1, count = 4.
  - Drain → 1111 through 4444 only; 16'hDEAD never appears.
- Simultaneous push/pop when full: count = 4, push 16'h5555 with rd_ready = 1 → head 1111 popped, count stays 4, overflow stays 0.
  - Subsequent drain → 2222, 3333, 4444, 5555.
- Wrap-around: stream 10 words 16'h0001..16'h000A with rd_ready = 1 on every edge → one-edge latency, output order preserved across pointer wrap, count never exceeds 1.
- Reset mid-operation: with count = 3, assert rst_n = 0 for one edge while reg_wr = 0 → count = 0, rd_valid = 0, overflow = 0, and that push is not stored.
